shift_seq_ctrl: RTL

//  Command sequencer for the 4-bit universal shift register (sel: 00 hold, 01 right, 10 left, 11 load).
//  - Accepts one command at a time over a valid/ready handshake: load, clear, shift or rotate by N bits.
//  - Drives the register's sel, parallel-in and serial-in pins for the required number of cycles.
//  - Streams the exiting bit on sout, pulses done and presents the final contents on result.
//  - Sits between the host/test logic and the shift datapath; both share clk and rst.

---
 rtl/shift_ctrl_pkg.sv | 24 ++
 rtl/shift_seq_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: op codes, shift-register select codes and FSM states for shift_seq_ctrl
package shift_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHR   = 3'b010,
    OP_SHL   = 3'b011,
    OP_ROTR  = 3'b100,
    OP_ROTL  = 3'b101,
    OP_CLEAR = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
  function automatic logic is_shift(op_t o);
    return o inside {OP_SHR, OP_SHL, OP_ROTR, OP_ROTL};
  endfunction
  function automatic logic is_right(op_t o);
    return o == OP_SHR || o == OP_ROTR;
  endfunction
endpackage

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences load/clear/shift/rotate commands onto a universal shift register
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_cnt/cmd_data : command handshake from host
//   sin                                         : serial fill bit for SHR/SHL
//   usr_sel/usr_par/usr_il/usr_ir               : drive pins of the shift register
//   usr_q                                       : shift register contents
//   sout/sout_valid                             : bit leaving the register each shift cycle
//   busy/done/result                            : status and final contents
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sin,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_par,
  output logic             usr_il,
  output logic             usr_ir,
  input  logic [WIDTH-1:0] usr_q,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] data;
  logic             shifting, right, fill;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      op    <= OP_NOP;
      rem   <= '0;
      data  <= '0;
    end else
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            op    <= op_t'(cmd_op);
            rem   <= cmd_cnt;
            data  <= cmd_data;
            state <= (op_t'(cmd_op) == OP_LOAD || op_t'(cmd_op) == OP_CLEAR) ? S_LOAD :
                     (is_shift(op_t'(cmd_op)) && cmd_cnt != '0) ? S_SHIFT : S_DONE;
          end
        S_LOAD: state <= S_DONE;
        S_SHIFT: begin
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
  // Rotates feed the exiting bit back in; plain shifts fill from sin.
  always_comb begin
    shifting   = state == S_SHIFT;
    right      = is_right(op);
    fill       = (op == OP_SHR || op == OP_SHL) ? sin : right ? usr_q[0] : usr_q[WIDTH-1];
    usr_sel    = shifting ? (right ? SEL_SHR : SEL_SHL) : state == S_LOAD ? SEL_LOAD : SEL_HOLD;
    usr_par    = (state == S_LOAD && op == OP_LOAD) ? data : '0;
    usr_ir     = shifting && right && fill;
    usr_il     = shifting && !right && fill;
    sout       = shifting && (right ? usr_q[0] : usr_q[WIDTH-1]);
    sout_valid = shifting;
    busy       = state != S_IDLE;
    done       = state == S_DONE;
    result     = done ? usr_q : '0;
    cmd_ready  = rst && state == S_IDLE;
  end
endmodule
